bird_collision_tracker: RTL



---
 rtl/bird_collision_tracker.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/bird_collision_tracker.sv
// bird_collision_tracker
//   Resolves bird / obstacle (and optionally border) drawing requests into
//   per-frame collision events, tracks lives, runs a post-hit grace window
//   and drives the bird's showBird input so the bird blinks during grace.
//
// Optional feature macro: BIRD_BORDER_HIT_EN
//   defined   : bird over border pixels also counts as a hit.
//   undefined : borderDrawingRequest is ignored.
//
// Ports
//   clk, resetN             pixel clock, async active-low reset
//   startOfFrame            one-cycle pulse at the first pixel of a frame
//   restartGame             synchronous restart request
//   birdDrawingRequest      bird pixel opaque
//   birdHitEdgeCode[3:0]    {Left,Top,Right,Bottom} edge code of bird pixel
//   obstacleDrawingRequest  obstacle pixel opaque
//   borderDrawingRequest    border pixel opaque
//   collisionPulse          one-cycle pulse per registered hit
//   hitEdges[3:0]           OR of edge codes of the last registered hit
//   livesLeft[LIVES_W-1:0]  remaining lives
//   inGrace                 grace window active
//   showBird                bird visibility (blinks during grace)
//   gameOver                lives exhausted
module bird_collision_tracker #(
   parameter int unsigned INIT_LIVES   = 3,
   parameter int unsigned LIVES_W      = 3,
   parameter int unsigned GRACE_FRAMES = 60,
   parameter int unsigned GRACE_W      = 7,
   parameter int unsigned BLINK_BIT    = 2
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               startOfFrame,
   input  logic               restartGame,
   input  logic               birdDrawingRequest,
   input  logic [3:0]         birdHitEdgeCode,
   input  logic               obstacleDrawingRequest,
   input  logic               borderDrawingRequest,
   output logic               collisionPulse,
   output logic [3:0]         hitEdges,
   output logic [LIVES_W-1:0] livesLeft,
   output logic               inGrace,
   output logic               showBird,
   output logic               gameOver
);

   localparam int unsigned EDGE_W = 4;

   typedef enum logic [1:0] {
      ST_ACTIVE    = 2'd0,
      ST_GRACE     = 2'd1,
      ST_GAME_OVER = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic                 frame_hit_q, frame_hit_d;
   logic [EDGE_W-1:0]    frame_edges_q, frame_edges_d;
   logic [GRACE_W-1:0]   grace_cnt_q, grace_cnt_d;
   logic                 pulse_q, pulse_d;
   logic [EDGE_W-1:0]    hit_edges_q, hit_edges_d;
   logic [LIVES_W-1:0]   lives_q, lives_d;
   logic                 in_grace_q, in_grace_d;
   logic                 show_bird_q, show_bird_d;
   logic                 game_over_q, game_over_d;

   logic                 pix_hit_c;
   logic [LIVES_W-1:0]   lives_dec_c;

   // Pixel-level overlap between the bird and anything that can hurt it
`ifdef BIRD_BORDER_HIT_EN
   assign pix_hit_c = birdDrawingRequest &&
                      (obstacleDrawingRequest || borderDrawingRequest);
`else
   logic unused_border;
   assign unused_border = borderDrawingRequest;
   assign pix_hit_c     = birdDrawingRequest && obstacleDrawingRequest;
`endif

   // Saturating life decrement
   assign lives_dec_c = (lives_q != '0) ? (lives_q - LIVES_W'(1)) : '0;

   // Next-state and registered-output logic
   always_comb begin
      state_d       = state_q;
      frame_hit_d   = frame_hit_q;
      frame_edges_d = frame_edges_q;
      grace_cnt_d   = grace_cnt_q;
      pulse_d       = 1'b0;
      hit_edges_d   = hit_edges_q;
      lives_d       = lives_q;

      if (restartGame) begin
         state_d       = ST_ACTIVE;
         frame_hit_d   = 1'b0;
         frame_edges_d = '0;
         grace_cnt_d   = '0;
         hit_edges_d   = '0;
         lives_d       = LIVES_W'(INIT_LIVES);
      end else if (startOfFrame) begin
         // Evaluate the finished frame, then start the new one with this
         // cycle's pixel only.
         unique case (state_q)
            ST_ACTIVE: begin
               if (frame_hit_q) begin
                  pulse_d     = 1'b1;
                  hit_edges_d = frame_edges_q;
                  lives_d     = lives_dec_c;
                  if (lives_dec_c == '0) begin
                     state_d = ST_GAME_OVER;
                  end else if (GRACE_FRAMES != 0) begin
                     state_d     = ST_GRACE;
                     grace_cnt_d = GRACE_W'(GRACE_FRAMES);
                  end
               end
            end
            ST_GRACE: begin
               if (grace_cnt_q <= GRACE_W'(1)) begin
                  grace_cnt_d = '0;
                  state_d     = ST_ACTIVE;
               end else begin
                  grace_cnt_d = grace_cnt_q - GRACE_W'(1);
               end
            end
            ST_GAME_OVER: begin
               lives_d = '0;
            end
            default: begin
               state_d = ST_ACTIVE;
            end
         endcase
         frame_hit_d   = pix_hit_c;
         frame_edges_d = pix_hit_c ? birdHitEdgeCode : '0;
      end else if (pix_hit_c) begin
         // Hits outside ACTIVE are accumulated but discarded at the next
         // frame boundary without being evaluated.
         frame_hit_d   = 1'b1;
         frame_edges_d = frame_edges_q | birdHitEdgeCode;
      end

      in_grace_d  = (state_d == ST_GRACE);
      game_over_d = (state_d == ST_GAME_OVER);
      show_bird_d = in_grace_d ? grace_cnt_d[BLINK_BIT] : 1'b1;
   end

   // State and output registers
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q       <= ST_ACTIVE;
         frame_hit_q   <= 1'b0;
         frame_edges_q <= '0;
         grace_cnt_q   <= '0;
         pulse_q       <= 1'b0;
         hit_edges_q   <= '0;
         lives_q       <= LIVES_W'(INIT_LIVES);
         in_grace_q    <= 1'b0;
         show_bird_q   <= 1'b1;
         game_over_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         frame_hit_q   <= frame_hit_d;
         frame_edges_q <= frame_edges_d;
         grace_cnt_q   <= grace_cnt_d;
         pulse_q       <= pulse_d;
         hit_edges_q   <= hit_edges_d;
         lives_q       <= lives_d;
         in_grace_q    <= in_grace_d;
         show_bird_q   <= show_bird_d;
         game_over_q   <= game_over_d;
      end
   end

   assign collisionPulse = pulse_q;
   assign hitEdges       = hit_edges_q;
   assign livesLeft      = lives_q;
   assign inGrace        = in_grace_q;
   assign showBird       = show_bird_q;
   assign gameOver       = game_over_q;

endmodule
